// File: rtl/led_fader_if.sv
// Pin-side bundle of the LED fader: enable and target in, PWM drive and status out.
interface led_fader_if #(
    parameter int LEVELS = 64
);
    logic                        en;
    logic                        led_in;
    logic                        led_out;
    logic [$clog2(LEVELS+1)-1:0] level;
    logic                        busy;

    modport master (output en, output led_in, input led_out, input level, input busy);
    modport slave  (input en, input led_in, output led_out, output level, output busy);
endinterface

// File: rtl/led_fader.sv
// LED fader: ramps brightness linearly between dark and full on and drives the pad with PWM.
// Define LED_FADER_GAMMA_EN for a quadratic duty curve (duty = level^2 over a LEVELS^2 frame).
module led_fader #(
    parameter int CLK_FREQ_KHz = 50000,
    parameter int PWM_FREQ_Hz  = 1000,
    parameter int LEVELS       = 64,
    parameter int FADE_MS      = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    led_fader_if.slave bus
);
    localparam int LW = $clog2(LEVELS + 1);
`ifdef LED_FADER_GAMMA_EN
    localparam int PWM_MAX = LEVELS * LEVELS;
    localparam int DW      = 2 * LW;
`else
    localparam int PWM_MAX = LEVELS;
    localparam int DW      = LW;
`endif
    localparam int PRE_RAW   = (CLK_FREQ_KHz * 1000) / (PWM_FREQ_Hz * PWM_MAX);
    localparam int PRESCALE  = (PRE_RAW < 1) ? 1 : PRE_RAW;
    localparam int STEP_RAW  = (CLK_FREQ_KHz * FADE_MS) / LEVELS;
    localparam int STEP_CLKS = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW        = $clog2(PWM_MAX);
    localparam int TW        = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PWM_MAX - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(STEP_CLKS - 1);
    localparam logic [LW-1:0] LV_MAX   = LW'(LEVELS);

    typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic          led_out_q, led_out_d;
    logic          busy_q, busy_d;
    logic          step_tick;
    logic          pre_wrap;

    // Saturating one-step move of the brightness level.
    function automatic logic [LW-1:0] step_level(input logic [LW-1:0] lvl, input logic up);
        if (up) return (lvl >= LV_MAX) ? LV_MAX : lvl + 1'b1;
        return (lvl == '0) ? '0 : lvl - 1'b1;
    endfunction

    function automatic logic [DW-1:0] duty_of(input logic [LW-1:0] lvl);
`ifdef LED_FADER_GAMMA_EN
        return DW'(lvl) * DW'(lvl);
`else
        return lvl;
`endif
    endfunction

    // PWM timebase runs regardless of enable; only the pad drive is gated.
    always_comb begin
        pre_d     = pre_q;
        pwm_cnt_d = pwm_cnt_q;
        pre_wrap  = (pre_q == PRE_LAST);
        pre_d     = pre_wrap ? '0 : pre_q + 1'b1;
        if (pre_wrap) pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
        led_out_d = bus.en & (DW'(pwm_cnt_q) < duty_of(level_q));
    end

    // Direction is settled first so a coinciding tick steps the new way.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        tmr_d     = tmr_q;
        step_tick = 1'b0;
        if (bus.en) begin
            step_tick = (tmr_q == TMR_LAST);
            tmr_d     = step_tick ? '0 : tmr_q + 1'b1;
            case (state_q)
                OFF:     if (bus.led_in)  state_d = RISE;
                ON:      if (!bus.led_in) state_d = FALL;
                RISE:    if (!bus.led_in) state_d = FALL;
                FALL:    if (bus.led_in)  state_d = RISE;
                default: state_d = OFF;
            endcase
            if (step_tick && state_d == RISE) begin
                level_d = step_level(level_q, 1'b1);
                if (level_d == LV_MAX) state_d = ON;
            end else if (step_tick && state_d == FALL) begin
                level_d = step_level(level_q, 1'b0);
                if (level_d == '0) state_d = OFF;
            end
        end
        busy_d = (state_d == RISE) || (state_d == FALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF;
            level_q   <= '0;
            tmr_q     <= '0;
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            tmr_q     <= tmr_d;
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.led_out = led_out_q;
    assign bus.level   = level_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: goal-seeking brightness model checked every cycle plus directed scenarios.
module tb_led_fader;
    localparam int L   = 8;
    localparam int CKK = 1;
    localparam int PFH = 125;
    localparam int FMS = 64;
`ifdef LED_FADER_GAMMA_EN
    localparam int PMAX = L * L;
`else
    localparam int PMAX = L;
`endif
    localparam int PRE_R = (CKK * 1000) / (PFH * PMAX);
    localparam int PRE   = (PRE_R < 1) ? 1 : PRE_R;
    localparam int STP_R = (CKK * FMS) / L;
    localparam int STP   = (STP_R < 1) ? 1 : STP_R;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    bit   chk_on = 1'b0;
    int   hi;
    int   bad;

    led_fader_if #(.LEVELS(L)) bus ();

    led_fader #(.CLK_FREQ_KHz(CKK), .PWM_FREQ_Hz(PFH), .LEVELS(L), .FADE_MS(FMS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int tb_duty(input int l);
`ifdef LED_FADER_GAMMA_EN
        return l * l;
`else
        return l;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Brightness seeks the goal set by led_in, one level per fade tick, while enabled.
    int m_lvl = 0, m_tmr = 0, m_ph = 0, m_pwm = 0, m_goal;
    bit m_busy = 1'b0, m_led = 1'b0, m_tick, m_mov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lvl = 0; m_tmr = 0; m_ph = 0; m_pwm = 0; m_busy = 1'b0; m_led = 1'b0;
        end else begin
            m_led = bus.en && (m_pwm < tb_duty(m_lvl));
            if (m_ph == PRE - 1) begin
                m_ph  = 0;
                m_pwm = (m_pwm + 1) % PMAX;
            end else begin
                m_ph = m_ph + 1;
            end
            if (bus.en) begin
                m_tick = (m_tmr == STP - 1);
                m_tmr  = (m_tmr + 1) % STP;
                m_goal = bus.led_in ? L : 0;
                m_mov  = m_busy || (m_lvl != m_goal);
                if (m_mov && m_tick)
                    m_lvl = bus.led_in ? ((m_lvl < L) ? m_lvl + 1 : L) : ((m_lvl > 0) ? m_lvl - 1 : 0);
                m_busy = m_mov && !(m_tick && m_lvl == m_goal);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_led_out", int'(bus.led_out), int'(m_led));
            check("model_level", int'(bus.level), m_lvl);
            check("model_busy", int'(bus.busy), int'(m_busy));
        end
    end

    task automatic wait_level(input int tgt, input int lim, input string nm);
        int n = 0;
        while (int'(bus.level) != tgt && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(nm, int'(bus.level), tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.led_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Idle: dark and steady.
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            hi += int'(bus.led_out);
        end
        check("idle_led_hi", hi, 0);
        check("idle_level", int'(bus.level), 0);
        check("idle_busy", int'(bus.busy), 0);

        // Full rise.
        bus.led_in = 1'b1;
        @(negedge clk);
        check("rise_busy", int'(bus.busy), 1);
        wait_level(L, 64, "rise_reach_full");
        check("on_busy", int'(bus.busy), 0);
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            hi += int'(bus.led_out);
        end
        check("on_led_hi", hi, 16);

        // Full fall, then rise to mid level and reverse.
        bus.led_in = 1'b0;
        wait_level(0, 80, "fall_reach_zero");
        check("off_busy", int'(bus.busy), 0);
        bus.led_in = 1'b1;
        wait_level(4, 48, "rise_reach_4");
        hi = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            hi += int'(bus.led_out);
            if (k == 7) bus.led_in = 1'b0;
        end
`ifndef LED_FADER_GAMMA_EN
        check("frame_hi_lvl4", hi, 4);
`endif
        check("rev_level", int'(bus.level), 3);
        check("rev_busy", int'(bus.busy), 1);
        repeat (24) @(negedge clk);
        check("rev_fall_level", int'(bus.level), 0);
        check("rev_fall_busy", int'(bus.busy), 0);

        // Enable dropped mid-fade.
        bus.led_in = 1'b1;
        wait_level(5, 64, "rise_reach_5");
        bus.en = 1'b0;
        @(negedge clk);
        check("en0_led_next", int'(bus.led_out), 0);
        hi = 0;
        bad = 0;
        repeat (39) begin
            @(negedge clk);
            hi += int'(bus.led_out);
            if (int'(bus.level) != 5) bad++;
        end
        check("en0_led_hi", hi, 0);
        check("en0_level_moves", bad, 0);
        check("en0_level", int'(bus.level), 5);
        bus.en = 1'b1;
        repeat (7) @(negedge clk);
        check("resume_hold", int'(bus.level), 5);
        @(negedge clk);
        check("resume_step", int'(bus.level), 6);

        // Asynchronous reset between edges.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", int'(bus.led_out), 0);
        check("arst_level", int'(bus.level), 0);
        check("arst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_level", int'(bus.level), 0);
        check("post_rst_busy", int'(bus.busy), 1);
        wait_level(L, 70, "post_rst_reach_full");
        check("post_rst_on_busy", int'(bus.busy), 0);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage of the LED blinker. Consumes its 1-bit `led` toggle as `led_in` and drives the physical pin with PWM.
- Ramps brightness up or down linearly over a programmable fade time instead of hard switching.
- One clock domain.

Parameters:
- CLK_FREQ_KHz, 50000, system clock frequency in kHz.
- PWM_FREQ_Hz, 1000, target PWM frame rate in Hz.
- LEVELS, 64, number of brightness steps. Level range is 0..LEVELS. LEVELS = fully on. Must be >= 2.
- FADE_MS, 100, duration of a full 0→LEVELS ramp in ms.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  output enable. 0 forces the LED dark and freezes the fade.
- led_in  in  1  target state from the blinker (1 = on). Sampled every clock.
- led_out  out  1  registered PWM drive to the pad.
- level  out  clog2(LEVELS+1)  current brightness level, registered.
- busy  out  1  high while a fade is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - level=0, led_out=0, busy=0, state=OFF.
  - All timers/counters are 0.
- Derived constants:
  - PWM_MAX = LEVELS; LEVELS*LEVELS with gamma.
  - PRESCALE = max(1, CLK_FREQ_KHz*1000 / (PWM_FREQ_Hz*PWM_MAX)).
  - STEP_CLKS = max(1, CLK_FREQ_KHz*FADE_MS / LEVELS).
  - All are integer division, evaluated at elaboration. Counter widths are clog2 of each range.
- PWM:
  - Prescaler counts 0..PRESCALE-1.
  - pwm_cnt advances on prescaler wrap, counts 0..PWM_MAX-1, then wraps to 0.
  - duty = level (linear).
  - led_out <= en & (pwm_cnt < duty). One clock of latency.
  - level=0 gives constant 0. level=LEVELS gives constant 1.
- Fade timer:
  - Free-running counter 0..STEP_CLKS-1, runs while en=1.
  - step_tick is asserted on the wrap cycle.
- State machine OFF / RISE / ON / FALL, evaluated every clock with en=1:
  - OFF: led_in=1 → RISE.
  - ON: led_in=0 → FALL.
  - RISE:
    - On step_tick, level+1.
    - On the tick where level becomes LEVELS → ON.
    - led_in=0 → FALL immediately; level is kept.
  - FALL:
    - On step_tick, level-1.
    - On the tick where level becomes 0 → OFF.
    - led_in=1 → RISE immediately; level is kept.
  - When a reversal and a step_tick coincide, the step is applied in the new direction.
  - level never exceeds LEVELS and never underflows below 0 (saturating).
- busy = (state==RISE | state==FALL), registered together with state.
- en=0:
  - State, level and fade timer hold.
  - The PWM counters keep running.
  - led_out=0 from the next clock.
  - On en returning to 1, operation resumes from the held values. A led_in change made while en=0 is acted on at the first enabled clock.
- led_in is expected synchronous to clk. It is not resynchronised.

Optional Feature:
- Macro: LED_FADER_GAMMA_EN.
- Defined:
  - PWM_MAX = LEVELS*LEVELS and duty = level*level (quadratic perceptual curve).
  - Same level sequencing and timing as the linear case. Only the duty mapping and PWM period change.
  - The multiplier output width is 2*clog2(LEVELS+1).
- Undefined: linear duty = level, and no multiplier is instantiated.

Test Plan (CLK_FREQ_KHz=1, PWM_FREQ_Hz=125, LEVELS=8, FADE_MS=64 → PRESCALE=1, STEP_CLKS=8, PWM period 8 clocks):
- Reset with led_in=0, en=1, run 100 clocks → level=0, led_out=0 every cycle, busy=0.
- led_in 0→1:
  - busy=1 the next clock.
  - level increments by 1 exactly every 8 clocks and reaches 8 within 64 clocks.
  - Then state=ON, busy=0, led_out=1 constantly.
- Rising at level=4, hold led_in=1 for one PWM frame → led_out high exactly 4 of 8 clocks (pwm_cnt 0..3). Then drop led_in=0 → next step_tick gives level=3, and level reaches 0 after 4 ticks (32 clocks) with busy=0.
- Mid-fade at level=5, drive en=0 for 40 clocks:
  - led_out=0 from the next clock; level stays 5.
  - en=1 → fade resumes and the next step comes 8 clocks later.
- Pull rst_n low between clock edges mid-fade → led_out, level and busy go to 0 without a clock edge. Release with led_in=1 → a fresh RISE from 0.
- With LED_FADER_GAMMA_EN defined (PRESCALE=1, PWM period 64 clocks) → level=4 gives led_out high 16 of 64 clocks; level=8 gives constant 1.
